square_wave_gen: RTL and testbench
==================================

Name: square_wave_gen

Overview:
Parametrised square-wave / PWM generator. It produces a HIGH phase of m ticks and a LOW phase of n ticks, where one tick is TICK_DIV enabled clock cycles. Both the time base and the field widths are configurable. New m/n values are taken in glitch-free at period boundaries, and the block reports each completed period. It drives LED/7-seg blanking, buzzer and test-pattern outputs in the board designs.

Parameters:
W, 8, width of m and n fields and of the internal phase counter
TICK_DIV, 10, clock cycles per tick; legal range >= 1 (at 100 MHz, 10 gives a 100 ns tick)
PW (localparam), $clog2(TICK_DIV) with a minimum of 1, prescaler width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; when low, the generator freezes
m  input  W  HIGH phase length in ticks, unsigned
n  input  W  LOW phase length in ticks, unsigned
out  output  1  square wave, registered
period_done  output  1  one-clock pulse marking the end of a period, registered
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-high, and has priority over everything else.
  - On reset: state=IDLE, out=0, period_done=0, busy=0, prescaler=0, phase counter=0, m_sh=0, n_sh=0.
  - Reset asserted mid-phase: IDLE and out=0 at the next edge, with no period_done.
- FSM states: IDLE, HIGH, LOW. out is high only in HIGH. busy = (state != IDLE).
- en=0: prescaler, phase counter, state and out all hold; period_done=0. No other effect.
- IDLE with en=1 at edge k:
  - Capture m->m_sh and n->n_sh.
  - If m!=0, go to HIGH (out=1 at k+1).
  - Else if n!=0, go to LOW.
  - Else stay in IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1 on enabled cycles.
  - tick = en AND (prescaler == TICK_DIV-1). For TICK_DIV=1, tick = en.
  - The prescaler and phase counter clear to 0 on every phase entry.
- HIGH: the phase counter increments on each tick. On a tick with phase_cnt == m_sh-1, the phase ends.
  - If n_sh != 0, go to LOW.
  - Otherwise this is a period boundary.
- LOW: the phase ends on a tick with phase_cnt == n_sh-1. This is always a period boundary.
- Period boundary:
  - period_done=1 for exactly the next clock.
  - m_sh/n_sh are reloaded from m/n.
  - Next state is chosen by the new shadow values, using the same rule as IDLE entry (IDLE if both are 0; period_done is still pulsed).
- Timing with en held high:
  - HIGH lasts exactly m_sh*TICK_DIV clocks and LOW lasts n_sh*TICK_DIV clocks. Period = (m_sh+n_sh)*TICK_DIV clocks with no gap cycles.
  - m=0 gives a constant-low output; n=0 gives a constant-high output. period_done still pulses every period in both cases.
- m/n changes mid-period have no effect until the next boundary.
- Arithmetic: unsigned throughout. The phase counter is W bits wide and never exceeds 2^W-2, so there is no wrap-around.

Optional Feature:
Macro: SQW_ONESHOT_EN
- Defined:
  - Adds an input port oneshot (1 bit).
  - If oneshot=1 at a period boundary, the FSM enters a fourth state, DONE, instead of reloading. In DONE: out=0, busy=1.
  - DONE exits to IDLE only after en is sampled low. A new burst then requires en to be high again.
  - period_done still pulses on entry to DONE.
- Undefined: no oneshot port, no DONE state; operation is always continuous.

Test Plan:
1. TICK_DIV=10, m=3, n=2, en=1 from IDLE -> out=1 from clock 1 for 30 clocks, then 0 for 20 clocks, repeating. period_done pulses every 50 clocks, on clocks 51, 101, ...
2. m=0, n=5 -> out stays 0, period_done every 50 clocks. Then m=4, n=0 -> out constant 1 from the next boundary, period_done every 40 clocks.
3. m=3, n=2; change m to 1 at clock 15 -> first period is unchanged (30 high / 20 low), the following HIGH lasts 10 clocks.
4. en low for 7 clocks during HIGH (m=3, n=2) -> HIGH phase measures 37 clocks. out and counters frozen while en is low; no period_done during the freeze.
5. reset pulsed at clock 12 of HIGH -> out=0, busy=0 next edge, no period_done. After release, restart begins with a full 30-clock HIGH.
6. SQW_ONESHOT_EN, oneshot=1, m=2, n=1 -> single 20-high / 10-low burst, period_done at clock 31, out held 0 with busy=1. Drop en -> busy=0.

Source files
------------

// File: rtl/square_wave_gen.sv
// Square-wave / PWM generator: m ticks HIGH, n ticks LOW, one tick = TICK_DIV enabled clocks.
// Optional macro SQW_ONESHOT_EN adds a oneshot input that parks the FSM in DONE after one period.
module square_wave_gen #(
  parameter int W        = 8,
  parameter int TICK_DIV = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] m,
  input  logic [W-1:0] n,
`ifdef SQW_ONESHOT_EN
  input  logic         oneshot,
`endif
  output logic         out,
  output logic         period_done,
  output logic         busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

`ifdef SQW_ONESHOT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  phase_q, phase_d;
  logic [W-1:0]  m_sh_q, m_sh_d;
  logic [W-1:0]  n_sh_q, n_sh_d;
  logic          pd_d;
  logic          tick;
  logic          boundary;
  logic          enter;

  // Shared by IDLE entry and period-boundary reload.
  function automatic state_t pick(input logic [W-1:0] mv, input logic [W-1:0] nv);
    if (mv != '0)      return HIGH;
    else if (nv != '0) return LOW;
    else               return IDLE;
  endfunction

  assign tick = en && (presc_q == PRE_MAX);
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    phase_d  = phase_q;
    m_sh_d   = m_sh_q;
    n_sh_d   = n_sh_q;
    pd_d     = 1'b0;
    boundary = 1'b0;
    enter    = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          m_sh_d  = m;
          n_sh_d  = n;
          state_d = pick(m, n);
          enter   = 1'b1;
        end
      end
      HIGH: begin
        if (tick) begin
          if (phase_q == m_sh_q - W'(1)) begin
            if (n_sh_q != '0) begin
              state_d = LOW;
              enter   = 1'b1;
            end else begin
              boundary = 1'b1;
            end
          end else begin
            phase_d = phase_q + W'(1);
          end
        end
      end
      LOW: begin
        if (tick) begin
          if (phase_q == n_sh_q - W'(1)) boundary = 1'b1;
          else                           phase_d  = phase_q + W'(1);
        end
      end
`ifdef SQW_ONESHOT_EN
      DONE: begin
        if (!en) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if ((state_q == HIGH) || (state_q == LOW)) begin
      if (tick)    presc_d = '0;
      else if (en) presc_d = presc_q + PW'(1);
    end

    if (boundary) begin
      pd_d  = 1'b1;
      enter = 1'b1;
`ifdef SQW_ONESHOT_EN
      if (oneshot) state_d = DONE;
      else
`endif
      begin
        m_sh_d  = m;
        n_sh_d  = n;
        state_d = pick(m, n);
      end
    end

    // Every phase entry restarts the time base so phases are exact multiples of a tick.
    if (enter) begin
      presc_d = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      phase_q     <= '0;
      m_sh_q      <= '0;
      n_sh_q      <= '0;
      out         <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      m_sh_q      <= m_sh_d;
      n_sh_q      <= n_sh_d;
      out         <= (state_d == HIGH);
      period_done <= pd_d;
    end
  end

endmodule

// File: tb/tb_square_wave_gen.sv
// Scoreboard bench for square_wave_gen: stimulus queues per-cycle expectations, a monitor compares.
module tb_square_wave_gen;

  localparam int W = 8;
  localparam int TICK_DIV = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic [W-1:0] m = '0;
  logic [W-1:0] n = '0;
`ifdef SQW_ONESHOT_EN
  logic         oneshot = 1'b0;
`endif
  logic         out, period_done, busy;

  typedef struct {
    logic  e_out;
    logic  e_pd;
    logic  e_busy;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  square_wave_gen #(.W(W), .TICK_DIV(TICK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .m           (m),
    .n           (n),
`ifdef SQW_ONESHOT_EN
    .oneshot     (oneshot),
`endif
    .out         (out),
    .period_done (period_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // For each of the next cnt clock edges, queue what the outputs must show after that edge.
  task automatic run(input int cnt, input logic eo, input logic ep, input logic eb, input string tag);
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      e.e_out = eo; e.e_pd = ep; e.e_busy = eb; e.tag = tag;
      exp_q.push_back(e);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (out !== e.e_out || period_done !== e.e_pd || busy !== e.e_busy) begin
        failures++;
        $display("FAIL %s t=%0t got out=%b pd=%b busy=%b expected out=%b pd=%b busy=%b",
                 e.tag, $time, out, period_done, busy, e.e_out, e.e_pd, e.e_busy);
      end
    end
  end

  initial begin
    // Reset state
    run(2, 0, 0, 0, "reset");
    reset = 1'b0; en = 1'b1; m = 8'd3; n = 8'd2;

    // Test 1: 30 high / 20 low, period_done every 50 clocks
    run(30, 1, 0, 1, "t1_high");
    run(20, 0, 0, 1, "t1_low");
    run(1,  1, 1, 1, "t1_pd1");
    run(29, 1, 0, 1, "t1_high2");
    m = 8'd0; n = 8'd5;           // mid-period change, effective only at next boundary
    run(20, 0, 0, 1, "t1_low2");

    // Test 2: m=0 -> constant low, then n=0 -> constant high
    run(1,  0, 1, 1, "t2_pd_lowonly");
    run(49, 0, 0, 1, "t2_low");
    run(1,  0, 1, 1, "t2_pd_low2");
    m = 8'd4; n = 8'd0;
    run(49, 0, 0, 1, "t2_low3");
    run(1,  1, 1, 1, "t2_pd_to_high");
    run(39, 1, 0, 1, "t2_high");
    run(1,  1, 1, 1, "t2_pd_highonly");
    m = 8'd3; n = 8'd2;
    run(39, 1, 0, 1, "t2_high2");
    run(1,  1, 1, 1, "t2_pd_reload");

    // Test 3: change m to 1 at clock 15 of the 3/2 period
    run(14, 1, 0, 1, "t3_high_a");
    m = 8'd1;
    run(15, 1, 0, 1, "t3_high_b");
    run(20, 0, 0, 1, "t3_low");
    run(1,  1, 1, 1, "t3_pd");
    run(9,  1, 0, 1, "t3_short_high");
    m = 8'd3;
    run(20, 0, 0, 1, "t3_low2");
    run(1,  1, 1, 1, "t3_pd2");

    // Test 4: en low for 7 clocks during HIGH stretches it to 37 clocks
    run(9,  1, 0, 1, "t4_high_a");
    en = 1'b0;
    run(7,  1, 0, 1, "t4_frozen");
    en = 1'b1;
    run(20, 1, 0, 1, "t4_high_b");
    run(20, 0, 0, 1, "t4_low");
    run(1,  1, 1, 1, "t4_pd");

    // Test 5: reset at clock 12 of HIGH, then full restart
    run(11, 1, 0, 1, "t5_high_pre");
    reset = 1'b1;
    run(1,  0, 0, 0, "t5_reset");
    reset = 1'b0;
    run(30, 1, 0, 1, "t5_high");
    run(20, 0, 0, 1, "t5_low");
    run(1,  1, 1, 1, "t5_pd");

    // m=n=0 from IDLE stays idle with no pulse
    reset = 1'b1;
    run(1, 0, 0, 0, "z_reset");
    reset = 1'b0; m = 8'd0; n = 8'd0;
    run(3, 0, 0, 0, "z_idle");

`ifdef SQW_ONESHOT_EN
    // Test 6: single 20/10 burst, park in DONE, leave on en low
    en = 1'b0;
    run(1, 0, 0, 0, "t6_idle");
    oneshot = 1'b1; m = 8'd2; n = 8'd1; en = 1'b1;
    run(20, 1, 0, 1, "t6_high");
    run(10, 0, 0, 1, "t6_low");
    run(1,  0, 1, 1, "t6_pd_done");
    run(5,  0, 0, 1, "t6_done_hold");
    en = 1'b0;
    run(1,  0, 0, 0, "t6_exit");
`endif

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
